// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction-fetch and load/store requesters.
// Each access runs for a fixed number of memory cycles. A fetch of EOF_ADDR halts all further traffic.
module mem_port_arbiter #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                MEM_LAT  = 1,
  parameter logic [ADDR_W-1:0] EOF_ADDR = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_read,
  output logic              m_write,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DATA  = 3'd2,
    S_DONE  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [3:0]        r_cnt;
  logic              r_last_d;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_if_instr;
  logic [DATA_W-1:0] r_d_rdata;
  logic              w_grant_f;
  logic              w_grant_d;
  logic              w_eof;
  logic              w_busy;

  assign w_eof  = (if_addr == EOF_ADDR);
  assign w_busy = (r_state == S_FETCH) || (r_state == S_DATA);

  always_comb begin
    w_grant_f    = 1'b0;
    w_grant_d    = 1'b0;
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (if_req && d_req) begin
          w_grant_f = r_last_d;
          w_grant_d = !r_last_d;
        end else begin
          w_grant_f = if_req;
          w_grant_d = d_req;
        end
        if (w_grant_f)      w_next_state = w_eof ? S_HALT : S_FETCH;
        else if (w_grant_d) w_next_state = S_DATA;
      end
      S_FETCH, S_DATA: if (r_cnt == 4'd0) w_next_state = S_DONE;
      S_DONE:          w_next_state = S_IDLE;
      S_HALT:          w_next_state = S_HALT;
      default:         w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    m_read   = (r_state == S_FETCH) || ((r_state == S_DATA) && !r_we);
    m_write  = (r_state == S_DATA) && r_we;
    m_addr   = w_busy ? r_addr : '0;
    m_wdata  = m_write ? r_wdata : '0;
    if_ready = (r_state == S_DONE) && !r_last_d;
    d_ready  = (r_state == S_DONE) && r_last_d;
    halted   = (r_state == S_HALT);
    if_instr = r_if_instr;
    d_rdata  = r_d_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      // Reset as if fetch was granted last, so data wins the first tie.
      r_last_d   <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_instr <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_IDLE) begin
        if (w_grant_f && !w_eof) begin
          r_addr   <= if_addr;
          r_we     <= 1'b0;
          r_wdata  <= '0;
          r_cnt    <= LAT_M1;
          r_last_d <= 1'b0;
        end else if (w_grant_d) begin
          r_addr   <= d_addr;
          r_we     <= d_we;
          r_wdata  <= d_wdata;
          r_cnt    <= LAT_M1;
          r_last_d <= 1'b1;
        end
      end
      if (w_busy) begin
        if (r_cnt != 4'd0) begin
          r_cnt <= r_cnt - 4'd1;
        end else if (r_state == S_FETCH) begin
          r_if_instr <= m_rdata;
        end else if (!r_we) begin
          r_d_rdata <= m_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=1 (u1), one with MEM_LAT=3 (u3).
// Both share stimulus; each scenario checks only the instance it targets.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, m_rdata;

  logic        a1_if_ready, a1_d_ready, a1_m_read, a1_m_write, a1_halted;
  logic [31:0] a1_if_instr, a1_d_rdata, a1_m_addr, a1_m_wdata;
  logic        a3_if_ready, a3_d_ready, a3_m_read, a3_m_write, a3_halted;
  logic [31:0] a3_if_instr, a3_d_rdata, a3_m_addr, a3_m_wdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(1)) u1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(a1_if_ready), .if_instr(a1_if_instr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(a1_d_ready), .d_rdata(a1_d_rdata),
    .m_addr(a1_m_addr), .m_wdata(a1_m_wdata), .m_read(a1_m_read), .m_write(a1_m_write),
    .m_rdata(m_rdata), .halted(a1_halted)
  );

  mem_port_arbiter #(.MEM_LAT(3)) u3 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(a3_if_ready), .if_instr(a3_if_instr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(a3_d_ready), .d_rdata(a3_d_rdata),
    .m_addr(a3_m_addr), .m_wdata(a3_m_wdata), .m_read(a3_m_read), .m_write(a3_m_write),
    .m_rdata(m_rdata), .halted(a3_halted)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
  endtask

  initial begin
    idle_inputs();

    // Reset state, then a single fetch on the 1-cycle instance.
    do_reset();
    check_val("rst_if_ready", 32'(a1_if_ready), 32'd0);
    check_val("rst_d_ready",  32'(a1_d_ready),  32'd0);
    check_val("rst_if_instr", a1_if_instr, 32'h0);
    check_val("rst_d_rdata",  a1_d_rdata,  32'h0);
    check_val("rst_m_read",   32'(a1_m_read),   32'd0);
    check_val("rst_m_write",  32'(a1_m_write),  32'd0);
    check_val("rst_m_addr",   a1_m_addr,   32'h0);
    check_val("rst_halted",   32'(a1_halted),   32'd0);
    if_req = 1'b1; if_addr = 32'h0000_3000; m_rdata = 32'h2008_0005;
    @(negedge clk);
    check_val("f1_m_read", 32'(a1_m_read), 32'd1);
    check_val("f1_m_addr", a1_m_addr, 32'h0000_3000);
    check_val("f1_if_ready_early", 32'(a1_if_ready), 32'd0);
    @(negedge clk);
    check_val("f1_if_ready", 32'(a1_if_ready), 32'd1);
    check_val("f1_if_instr", a1_if_instr, 32'h2008_0005);
    check_val("f1_m_read_done", 32'(a1_m_read), 32'd0);
    check_val("f1_m_addr_done", a1_m_addr, 32'h0);
    if_req = 1'b0;
    @(negedge clk);
    check_val("f1_if_ready_drop", 32'(a1_if_ready), 32'd0);
    check_val("f1_if_instr_hold", a1_if_instr, 32'h2008_0005);

    // Store on the 3-cycle instance.
    idle_inputs();
    do_reset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF; m_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val($sformatf("st_m_write_%0d", i), 32'(a3_m_write), 32'd1);
      check_val($sformatf("st_m_read_%0d", i),  32'(a3_m_read),  32'd0);
      check_val($sformatf("st_m_addr_%0d", i),  a3_m_addr,  32'h10);
      check_val($sformatf("st_m_wdata_%0d", i), a3_m_wdata, 32'hDEAD_BEEF);
      check_val($sformatf("st_d_ready_%0d", i), 32'(a3_d_ready), 32'd0);
    end
    @(negedge clk);
    check_val("st_d_ready",  32'(a3_d_ready), 32'd1);
    check_val("st_m_write_done", 32'(a3_m_write), 32'd0);
    check_val("st_m_wdata_done", a3_m_wdata, 32'h0);
    check_val("st_d_rdata",  a3_d_rdata, 32'h0);
    d_req = 1'b0;
    @(negedge clk);
    check_val("st_d_ready_drop", 32'(a3_d_ready), 32'd0);

    // Both requesters held from reset: data, fetch, data, fetch every 3 cycles.
    idle_inputs();
    do_reset();
    if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_addr = 32'h40; m_rdata = 32'h0BAD_F00D;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val($sformatf("alt_m_addr_%0d", k), a1_m_addr, (k % 2 == 0) ? 32'h40 : 32'h100);
      check_val($sformatf("alt_m_read_%0d", k), 32'(a1_m_read), 32'd1);
      @(negedge clk);
      check_val($sformatf("alt_d_ready_%0d", k),  32'(a1_d_ready),  (k % 2 == 0) ? 32'd1 : 32'd0);
      check_val($sformatf("alt_if_ready_%0d", k), 32'(a1_if_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
      @(negedge clk);
      check_val($sformatf("alt_gap_read_%0d", k), 32'(a1_m_read), 32'd0);
    end
    check_val("alt_d_rdata",  a1_d_rdata,  32'h0BAD_F00D);
    check_val("alt_if_instr", a1_if_instr, 32'h0BAD_F00D);

    // End-of-program fetch halts and ignores later requests.
    idle_inputs();
    do_reset();
    if_req = 1'b1; if_addr = 32'hFFFF_FFFF;
    @(negedge clk);
    check_val("h_halted",   32'(a1_halted),   32'd1);
    check_val("h_m_read",   32'(a1_m_read),   32'd0);
    check_val("h_if_ready", 32'(a1_if_ready), 32'd0);
    check_val("h_m_addr",   a1_m_addr,   32'h0);
    if_req = 1'b0; d_req = 1'b1; d_addr = 32'h20;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_val($sformatf("h_ign_read_%0d", i),  32'(a1_m_read),  32'd0);
      check_val($sformatf("h_ign_ready_%0d", i), 32'(a1_d_ready), 32'd0);
      check_val($sformatf("h_sticky_%0d", i),    32'(a1_halted),  32'd1);
    end
    d_req = 1'b0;
    do_reset();
    check_val("h_rst_clear", 32'(a1_halted), 32'd0);

    // Reset in the second busy cycle of a 3-cycle load, then a clean load.
    idle_inputs();
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; m_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check_val("rl_m_read_1", 32'(a3_m_read), 32'd1);
    @(negedge clk);
    check_val("rl_m_read_2", 32'(a3_m_read), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_val("rl_m_read_rst",  32'(a3_m_read),  32'd0);
    check_val("rl_m_addr_rst",  a3_m_addr,  32'h0);
    check_val("rl_d_ready_rst", 32'(a3_d_ready), 32'd0);
    check_val("rl_d_rdata_rst", a3_d_rdata, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val($sformatf("rl2_m_read_%0d", i),  32'(a3_m_read),  32'd1);
      check_val($sformatf("rl2_d_ready_%0d", i), 32'(a3_d_ready), 32'd0);
    end
    @(negedge clk);
    check_val("rl2_d_ready", 32'(a3_d_ready), 32'd1);
    check_val("rl2_d_rdata", a3_d_rdata, 32'hCAFE_F00D);
    check_val("rl2_m_read_done", 32'(a3_m_read), 32'd0);
    d_req = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
